// File: rtl/fwd_scoreboard_unit.sv
// Forwarding / load-use hazard unit with a shift-register scoreboard,
// mem-to-mem store-data bypass and a saturating stall counter.
module fwd_scoreboard_unit #(
  parameter int REG_W    = 4,
  parameter int DATA_W   = 16,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit M2M_EN   = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   flush,
  input  logic                   cnt_clr,
  input  logic                   id_valid,
  input  logic [NSRC*REG_W-1:0]  id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [NSRC-1:0]        id_src_st,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_we,
  input  logic                   id_is_load,
  input  logic [NSRC*DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0]      ex_result,
  input  logic [DATA_W-1:0]      mem_ld_data,
  output logic [NSRC*DATA_W-1:0] op_data,
  output logic                   id_stall,
  output logic                   mem_to_mem,
  output logic [DATA_W-1:0]      m2m_data,
  output logic [CNT_W-1:0]       stall_cnt
);

  // entry2 always exists: it holds the load result for mem-to-mem
  localparam int ND = (DEPTH < 3) ? 3 : DEPTH;

  logic [ND-1:0]     vld_q, vld_d;
  logic [ND-1:0]     we_q, we_d;
  logic [2:0]        ld_q, ld_d;
  logic [1:0]        m2m_q, m2m_d;
  logic [REG_W-1:0]  rd_q  [ND];
  logic [REG_W-1:0]  rd_d  [ND];
  logic [DATA_W-1:0] dat_q [1:ND-1];
  logic [DATA_W-1:0] dat_d [1:ND-1];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NSRC-1:0]   ld_hz;
  logic [NSRC-1:0]   m2m_hit;
  logic [REG_W-1:0]  src;
  logic              src_ok;

  always_comb begin
    op_data = rf_data;
    ld_hz   = '0;
    m2m_hit = '0;
    src     = '0;
    src_ok  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      src    = id_src[i*REG_W +: REG_W];
      src_ok = id_src_used[i] && !(ZERO_REG && src == '0);
      // oldest first so the youngest match overwrites
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (src_ok && vld_q[k] && we_q[k] && rd_q[k] == src) begin
          if (k == 1 && ld_q[1])
            op_data[i*DATA_W +: DATA_W] = mem_ld_data;
          else
            op_data[i*DATA_W +: DATA_W] = dat_q[k];
        end
      end
      if (src_ok && vld_q[0] && we_q[0] && rd_q[0] == src) begin
        op_data[i*DATA_W +: DATA_W] = ex_result;
        if (ld_q[0]) begin
          if (M2M_EN && id_src_st[i])
            m2m_hit[i] = 1'b1;
          else
            ld_hz[i] = 1'b1;
        end
      end
    end
  end

  assign id_stall   = id_valid & ~flush & (|ld_hz);
  assign mem_to_mem = vld_q[1] & m2m_q[1] & vld_q[2] & ld_q[2];
  assign m2m_data   = dat_q[2];

  always_comb begin
    vld_d = vld_q;
    we_d  = we_q;
    ld_d  = ld_q;
    m2m_d = m2m_q;
    rd_d  = rd_q;
    dat_d = dat_q;
    if (!hold) begin
      vld_d[0] = id_valid & ~id_stall & ~flush;
      we_d[0]  = id_we;
      ld_d[0]  = id_is_load;
      m2m_d[0] = |m2m_hit;
      rd_d[0]  = id_rd;
      vld_d[1] = vld_q[0] & ~flush;
      we_d[1]  = we_q[0];
      ld_d[1]  = ld_q[0];
      m2m_d[1] = m2m_q[0];
      rd_d[1]  = rd_q[0];
      dat_d[1] = ex_result;
      vld_d[2] = vld_q[1];
      we_d[2]  = we_q[1];
      ld_d[2]  = ld_q[1];
      rd_d[2]  = rd_q[1];
      dat_d[2] = ld_q[1] ? mem_ld_data : dat_q[1];
      for (int k = 3; k < ND; k++) begin
        vld_d[k] = vld_q[k-1];
        we_d[k]  = we_q[k-1];
        rd_d[k]  = rd_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (id_stall && !hold && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      we_q  <= '0;
      ld_q  <= '0;
      m2m_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < ND; k++) rd_q[k] <= '0;
      for (int k = 1; k < ND; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      we_q  <= we_d;
      ld_q  <= ld_d;
      m2m_q <= m2m_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      dat_q <= dat_d;
    end
  end

endmodule
